// File: rtl/regfile_dump.sv
// 32x32 register file ($0 hardwired to zero) with two combinational read ports and a handshake dump engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_dump #(
  parameter int unsigned DUMP_FIRST = 0,
  parameter int unsigned DUMP_LAST  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        dump_req,
  output logic        dump_busy,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] regs [32];
  logic [4:0]  idx_nxt;
  logic [31:0] data_nxt;
  logic [4:0]  sel_idx;
  logic [31:0] sel_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst && re1 && raddr1 != '0) begin
      rdata1 = regs[raddr1];
`ifdef REGFILE_BYPASS_EN
      if (we && raddr1 == waddr) rdata1 = wdata;
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && raddr2 != '0) begin
      rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (we && raddr2 == waddr) rdata2 = wdata;
`endif
    end
  end

  // Index the dump engine loads next: first index when starting, successor while running.
  assign sel_idx = (state == RUN) ? dump_idx + 5'd1 : 5'(DUMP_FIRST);

  // Dump always forwards a same-cycle write, regardless of the read-port bypass option.
  always_comb begin
    sel_val = regs[sel_idx];
    if (sel_idx == '0)
      sel_val = '0;
    else if (we && waddr == sel_idx)
      sel_val = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      state     <= state_nxt;
      dump_idx  <= idx_nxt;
      dump_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = dump_idx;
    data_nxt  = dump_data;
    case (state)
      IDLE: begin
        if (dump_req) begin
          state_nxt = RUN;
          idx_nxt   = sel_idx;
          data_nxt  = sel_val;
        end
      end
      RUN: begin
        if (dump_ready) begin
          if (dump_idx == 5'(DUMP_LAST)) begin
            state_nxt = DONE;
          end else begin
            idx_nxt  = sel_idx;
            data_nxt = sel_val;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_valid = (state == RUN);
  assign dump_busy  = (state == RUN);
  assign dump_done  = (state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: array/queue reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_regfile_dump;

  localparam int unsigned FIRST = 0;
  localparam int unsigned LAST  = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        dump_req = 1'b0;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;

  regfile_dump #(.DUMP_FIRST(FIRST), .DUMP_LAST(LAST)) dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, dump progress, held beat value.
  logic [31:0] mem [32];
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_new    = 1'b0;
  int unsigned m_idx    = 0;
  logic [31:0] m_hold   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_new    <= 1'b0;
      m_idx    <= 0;
    end else begin
      if (we && waddr != 5'd0) mem[waddr] <= wdata;
      m_done <= m_active && dump_ready && m_idx == LAST;
      if (!m_active && !m_done && dump_req) begin
        m_active <= 1'b1;
        m_idx    <= FIRST;
        m_new    <= 1'b1;
      end else if (m_active && dump_ready && m_idx < LAST) begin
        m_idx <= m_idx + 1;
        m_new <= 1'b1;
      end else begin
        m_new <= 1'b0;
        if (m_active && dump_ready) m_active <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic e, input logic [4:0] a);
    if (!rst || !e || a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return mem[a];
  endfunction

  // A new beat carries the register contents as they stand once the loading edge's write has landed.
  always @(negedge clk) begin
    check32("rdata1", rdata1, model_rd(re1, raddr1));
    check32("rdata2", rdata2, model_rd(re2, raddr2));
    check32("dump_valid", {31'd0, dump_valid}, {31'd0, m_active});
    check32("dump_busy", {31'd0, dump_busy}, {31'd0, m_active});
    check32("dump_done", {31'd0, dump_done}, {31'd0, m_done});
    if (m_active) begin
      check32("dump_idx", {27'd0, dump_idx}, m_idx);
      check32("dump_data", dump_data, m_new ? mem[m_idx] : m_hold);
    end
    m_hold <= m_new ? mem[m_idx] : m_hold;
  end

  logic [4:0]  q_idx [$];
  logic [31:0] q_data [$];
  int unsigned done_cnt = 0;

  always @(negedge clk) begin
    if (rst && dump_valid && dump_ready) begin
      q_idx.push_back(dump_idx);
      q_data.push_back(dump_data);
    end
    if (rst && dump_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_scoreboard();
    q_idx.delete();
    q_data.delete();
    done_cnt = 0;
  endtask

  task automatic check_beats(input string tag, input logic [31:0] r1_val);
    check32({tag, "_done_pulses"}, done_cnt, 32'd1);
    check32({tag, "_beat_count"}, q_idx.size(), 32'd32);
    for (int i = 0; i < q_idx.size(); i++) begin
      check32({tag, "_beat_idx"}, {27'd0, q_idx[i]}, 32'(i));
      check32({tag, "_beat_data"}, q_data[i], (i == 1) ? r1_val : 32'(i) * 32'h11);
    end
  endtask

  initial begin
    // Reads during reset
    re1 = 1'b1;
    re2 = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      #1;
      check32("reset_rdata1", rdata1, 32'h0);
      check32("reset_rdata2", rdata2, 32'h0);
    end
    check32("reset_valid", {31'd0, dump_valid}, 32'd0);
    check32("reset_busy", {31'd0, dump_busy}, 32'd0);
    check32("reset_idx", {27'd0, dump_idx}, 32'd0);
    check32("reset_data", dump_data, 32'h0);
    check32("reset_done", {31'd0, dump_done}, 32'd0);
    tick();
    rst = 1'b1;

    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      tick();
    end
    check32("post_reset_r31", rdata1, 32'h0);

    // Write then read r5
    re1 = 1'b0; re2 = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1 check32("r5_read", rdata1, 32'h12345678);
    re1 = 1'b0;
    #1 check32("r5_re_off", rdata1, 32'h0);
    tick();

    // Writes to r0 are dropped
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #1 check32("r0_read1", rdata1, 32'h0);
    check32("r0_read2", rdata2, 32'h0);
    tick();

    // Same-cycle write and read of r7
    re1 = 1'b0;
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; re2 = 1'b1; raddr2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    #1 check32("r7_same_cycle", rdata2, 32'hA5A5A5A5);
`else
    #1 check32("r7_same_cycle", rdata2, 32'h0);
`endif
    tick();
    we = 1'b0;
    #1 check32("r7_after", rdata2, 32'hA5A5A5A5);
    re2 = 1'b0;
    tick();

    // Preload rN = N*0x11
    for (int n = 1; n < 32; n++) begin
      we = 1'b1; waddr = 5'(n); wdata = 32'(n) * 32'h11;
      tick();
    end
    we = 1'b0;

    // Full-speed dump
    clear_scoreboard();
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (done_cnt != 0) break;
    end
    tick(); tick();
    check_beats("full", 32'h11);

    // Stalled dump, write to the held index r1 during the stall
    clear_scoreboard();
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int c = 0; c < 200; c++) begin
      dump_ready = (c % 4 == 0) || (c % 4 == 3);
      we = (c == 1);
      waddr = 5'd1;
      wdata = 32'hDEADBEEF;
      tick();
      if (done_cnt != 0) break;
    end
    we = 1'b0;
    dump_ready = 1'b1;
    tick(); tick();
    check_beats("stall", 32'h11);
    re1 = 1'b1; raddr1 = 5'd1;
    #1 check32("r1_after_stall", rdata1, 32'hDEADBEEF);
    re1 = 1'b0;

    // Reset in the middle of a dump
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick(); tick(); tick();
    #1 rst = 1'b0;
    #1;
    check32("midreset_valid", {31'd0, dump_valid}, 32'd0);
    check32("midreset_busy", {31'd0, dump_busy}, 32'd0);
    check32("midreset_idx", {27'd0, dump_idx}, 32'd0);
    check32("midreset_data", dump_data, 32'h0);
    re1 = 1'b1; raddr1 = 5'd3;
    #1 check32("midreset_r3", rdata1, 32'h0);
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check32("after_reset_idle", {31'd0, dump_valid}, 32'd0);
    check32("after_reset_r3", rdata1, 32'h0);
    re1 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- General-purpose register file for the OpenMIPS pipeline: 32 x 32-bit registers, $0 hardwired to zero.
- Acts as the responder to the decode stage's two register-read requests (read-enable plus 5-bit address per port).
- Accepts one write per cycle from write-back.
- Contains a handshake-driven dump engine that streams all 32 registers out for debug and trace.

Parameters:
- DUMP_FIRST, 0: first register index emitted by a dump (0..31).
- DUMP_LAST, 31: last register index emitted by a dump; must be >= DUMP_FIRST.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- we  in  1  write enable from write-back.
- waddr  in  5  write register index.
- wdata  in  32  write data.
- re1  in  1  read port 1 enable.
- raddr1  in  5  read port 1 index.
- rdata1  out  32  read port 1 data, combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  5  read port 2 index.
- rdata2  out  32  read port 2 data, combinational.
- dump_req  in  1  start-dump request; level sampled only in IDLE.
- dump_busy  out  1  high while in RUN.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_idx  out  5  register index of current beat.
- dump_data  out  32  register value of current beat.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - regs[1..31] = 0.
  - FSM = IDLE.
  - dump_busy = 0, dump_valid = 0, dump_idx = 0, dump_data = 0, dump_done = 0.
  - Reads stay combinational and return 0 for every address during reset.
- Write:
  - On posedge clk with we=1 and waddr!=0: regs[waddr] <= wdata.
  - waddr=0 is silently dropped.
- Read port k (combinational), in priority order:
  - re_k=0 -> 0.
  - raddr_k=0 -> 0.
  - Bypass hit (see Optional Feature) -> wdata.
  - Otherwise -> regs[raddr_k].
  - Both ports may read the same address in the same cycle.
- Dump FSM states: IDLE, RUN, DONE.
  - IDLE, dump_req=1:
    - Go to RUN.
    - dump_idx <= DUMP_FIRST.
    - dump_data <= value(DUMP_FIRST).
    - dump_valid <= 1.
    - dump_busy <= 1.
  - RUN, dump_valid & dump_ready & dump_idx<DUMP_LAST:
    - dump_idx <= dump_idx+1.
    - dump_data <= value(dump_idx+1).
    - Remain in RUN.
  - RUN, dump_valid & dump_ready & dump_idx==DUMP_LAST:
    - dump_valid <= 0, dump_busy <= 0.
    - Go to DONE.
  - RUN, dump_ready=0:
    - Hold dump_idx and dump_data stable.
    - A write to the held index does not change dump_data.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
  - dump_req is ignored in RUN and DONE; it is not queued.
- value(i) used by the dump engine:
  - Index 0 -> 0.
  - Else if we & waddr==i in the same cycle -> wdata (always, independent of the macro).
  - Else regs[i].
- Dump traffic never stalls or alters normal read/write ports.
- Beat throughput: 1 per cycle while dump_ready=1, so a full dump takes 32 beats plus 1 DONE cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port returns wdata when re_k & we & raddr_k==waddr & waddr!=0.
  - Gives write-before-read semantics in the same cycle; covers the WB->ID hazard.
- Undefined:
  - Reads return the pre-write array contents.
  - The new value is visible from the cycle after the write edge.

Test Plan:
- Reset, then read all 32 addresses on both ports with re=1 -> every rdata = 0x00000000. Assert rst=0 mid-dump -> dump_valid=0, FSM=IDLE immediately.
- Write 0x12345678 to r5, then next cycle raddr1=5, re1=1 -> rdata1=0x12345678. Same read with re1=0 -> 0.
- we=1, waddr=0, wdata=0xFFFFFFFF, then read r0 -> 0. Dump beat for idx 0 -> dump_data=0.
- Same-cycle write r7=0xA5A5A5A5 and raddr2=7, re2=1:
  - with REGFILE_BYPASS_EN -> rdata2=0xA5A5A5A5;
  - without it -> old value 0.
- Preload rN=N*0x11 for N=1..31, pulse dump_req with dump_ready=1 -> 32 consecutive beats idx 0..31, data N*0x11, then dump_done high for exactly 1 cycle.
- Dump with dump_ready toggling 1,0,0,1, and a write to the held index while stalled -> idx and data held through the stall, write not reflected, no beat lost or duplicated, total 32 beats.
